// File: rtl/mvu_pe_popacc_pkg.sv
// Shared MVAU processing-element definitions: default SIMD/SF/TDst and small
// elaboration-time helpers used by the popcount-accumulate datapath.
package mvu_pe_popacc_pkg;

  localparam int unsigned MVAU_SIMD = 4;
  localparam int unsigned MVAU_SF   = 3;
  localparam int unsigned MVAU_TDST = 8;

  function automatic int unsigned max1(input int unsigned v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/mvu_pe_popcount.sv
// Combinational popcount of SIMD one-bit products as a balanced pairwise adder
// tree; shared by the XNOR and standard-multiplier PE variants.
module mvu_pe_popcount #(
  parameter int unsigned SIMD = 4
) (
  input  logic [SIMD-1:0]            bits_i,
  output logic [$clog2(SIMD+1)-1:0]  cnt_o
);

  localparam int unsigned TPc = $clog2(SIMD + 1);

  logic [TPc-1:0] node [SIMD];

  // In-place tree: at level l, node[j] absorbs node[j+2^l] for j aligned to 2^(l+1).
  always_comb begin
    for (int unsigned i = 0; i < SIMD; i++) begin
      node[i] = TPc'(bits_i[i]);
    end
    for (int unsigned l = 0; l < 16; l++) begin
      if ((32'd1 << l) < SIMD) begin
        for (int unsigned j = 0; j < SIMD; j++) begin
          if (((j % (32'd2 << l)) == 0) && ((j + (32'd1 << l)) < SIMD)) begin
            node[j] = node[j] + node[j + (32'd1 << l)];
          end
        end
      end
    end
    cnt_o = node[0];
  end

endmodule

// File: rtl/mvu_pe_popacc.sv
// PE popcount-accumulate: registered popcount of each XNOR beat, accumulated
// over SF synapse-fold beats, one-cycle valid pulse per completed fold.
module mvu_pe_popacc
  import mvu_pe_popacc_pkg::*;
#(
  parameter int unsigned SIMD = MVAU_SIMD,
  parameter int unsigned SF   = MVAU_SF,
  parameter int unsigned TDst = MVAU_TDST
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            clr,
  input  logic            in_v,
  input  logic [SIMD-1:0] in_simd,
  output logic            out_v,
  output logic [TDst-1:0] out_acc
);

  localparam int unsigned TPc  = $clog2(SIMD + 1);
  localparam int unsigned TCnt = max1($clog2(SF));

  logic [TCnt-1:0] cnt_q, cnt_d;
  logic [TPc-1:0]  pc_d, pc_q;
  logic            pcv_q, first_q, last_q;
  logic [TDst-1:0] acc_q, acc_sum_d, out_acc_q;
  logic            out_v_q;
  logic            accept, first_d, last_d, fire;

  mvu_pe_popcount #(.SIMD(SIMD)) u_popcount (
    .bits_i (in_simd),
    .cnt_o  (pc_d)
  );

  always_comb begin
    accept  = in_v & ~clr;
    first_d = (cnt_q == '0);
    last_d  = (cnt_q == TCnt'(SF - 1));
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (in_v) begin
      cnt_d = last_d ? '0 : cnt_q + 1'b1;
    end
    // clr also kills the beat sitting in stage 1 so its fold is never emitted.
    fire      = pcv_q & ~clr;
    acc_sum_d = (first_q ? '0 : acc_q) + TDst'(pc_q);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q     <= '0;
      pc_q      <= '0;
      pcv_q     <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      acc_q     <= '0;
      out_acc_q <= '0;
      out_v_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pcv_q <= accept;
      if (accept) begin
        pc_q    <= pc_d;
        first_q <= first_d;
        last_q  <= last_d;
      end
      out_v_q <= 1'b0;
      if (fire) begin
        acc_q <= acc_sum_d;
        if (last_q) begin
          out_acc_q <= acc_sum_d;
          out_v_q   <= 1'b1;
        end
      end
    end
  end

  assign out_v   = out_v_q;
  assign out_acc = out_acc_q;

endmodule

// File: doc/mvu_pe_popacc.md
Name: mvu_pe_popacc

Overview:
- Downstream neighbour of the XNOR SIMD elements inside a processing element (PE) of the MVAU stream.
- Takes the SIMD 1-bit XNOR products of one beat, popcounts them in a registered stage, then accumulates the counts over SF synapse-fold beats.
- Emits one TDst-bit dot-product result per completed fold, with a single-cycle valid pulse, towards the PE output / threshold stage.

Parameters:
- SIMD, 4, number of XNOR SIMD lanes per beat (>=1).
- SF, 3, synapse fold: beats accumulated per output (>=1).
- TDst, 8, accumulator/output width; intended >= clog2(SIMD*SF+1), results wrap modulo 2^TDst.
- Local (derived, not overridable): TPc = clog2(SIMD+1), popcount width; TCnt = max(1, clog2(SF)), fold-counter width.

Ports:
- aclk  in  1  clock, all state on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort of the current partial fold.
- in_v  in  1  input beat valid; no backpressure, producer paces via in_v.
- in_simd  in  SIMD  XNOR products, bit i = out[0] of SIMD lane i.
- out_v  out  1  one-cycle pulse: out_acc holds a completed fold.
- out_acc  out  TDst  accumulated popcount of the last completed fold.

Behaviour:
- Reset state (aresetn=0, asynchronous):
  - fold counter, pc_q, pc_v, first/last flags, acc, out_acc: all 0.
  - out_v: 0.
- Stage 0 (input):
  - On in_v=1 and clr=0 the beat is accepted.
  - Tag the beat first = (cnt==0) and last = (cnt==SF-1).
  - cnt increments, wrapping SF-1 -> 0.
  - For SF=1 every beat is both first and last.
- Stage 1 (registered):
  - pc_q <= popcount(in_simd), zero-extended to TPc.
  - pc_v <= accepted; the first/last tags are registered alongside.
  - pc_q holds its value when no beat is accepted.
- Stage 2 (registered), when pc_v=1:
  - sum = (first ? 0 : acc) + zero-extend(pc_q), truncated to TDst.
  - acc <= sum.
  - If last: out_acc <= sum and out_v <= 1. Otherwise out_v <= 0.
- out_v is 0 in every cycle where stage 2 does not complete a fold.
- Latency: final beat accepted at cycle t -> out_v=1 and out_acc valid at t+2. Gaps in in_v only delay completion.
- Throughput: one beat per cycle; back-to-back folds need no bubble.
- out_acc holds its value until the next completed fold. It is not cleared by clr.
- clr=1 (synchronous, highest priority below reset):
  - cnt, pc_v and out_v are forced to 0 next cycle.
  - An in_v in the same cycle is discarded.
  - Any beat in flight in stages 1/2 is dropped; its fold is not emitted.
  - acc is left untouched (harmless, because the next beat is tagged first).
- aresetn asserted mid-fold: the partial fold is discarded and outputs go to their reset values immediately. After release the next accepted beat is first.
- Overflow: no saturation; arithmetic is modulo 2^TDst.

Decomposition:
- Shared definition file (mvau_defn): SIMD, SF, TDst.
- Module-local localparams: TPc, TCnt.
- Sub-module mvu_pe_popcount: purely combinational, balanced adder tree, SIMD-bit in -> TPc-bit out.
  - Instantiated once before the stage-1 register.
  - Reusable by the standard-multiplier PE variant.

Test Plan (SIMD=4, SF=3, TDst=8 unless stated):
- Reset: hold aresetn=0 with random inputs -> out_v=0 and out_acc=0; drop aresetn asynchronously mid-cycle -> outputs clear without waiting for an edge.
- Single fold, back-to-back beats 4'b1111, 4'b0101, 4'b0001 at cycles 0-2 -> out_v=1 only at cycle 4, out_acc=7.
- Gapped input: same three beats with 2 idle cycles between each -> out_acc=7, out_v exactly 2 cycles after the third beat; no spurious pulses.
- Consecutive folds: 1111 x3 then 0000 x3, no gap -> out_acc=12 (pulse at cycle 4), then out_acc=0 (pulse at cycle 7); 12 held between pulses.
- Abort: two beats of 1111, then clr=1 together with an in_v of 1111, then 0011 x3 -> no pulse for the aborted fold, then a single result of 6; repeat with aresetn pulsed mid-fold -> 6.
- Edge parameters:
  - SF=1, SIMD=1, beats 1, 0, 1 -> pulses every cycle with values 1, 0, 1.
  - SIMD=4, SF=3, TDst=3, beats 1111 x3 -> out_acc=4 (12 mod 8).
